// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the core-plus-memory view.
interface mem_arbiter_if #(
    parameter int AWIDTH = 14,
    parameter int DWIDTH = 32
);
    logic              if_req;
    logic [AWIDTH-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DWIDTH-1:0] if_rdata;
    logic              d_req;
    logic [3:0]        d_we;
    logic [AWIDTH-1:0] d_addr;
    logic [DWIDTH-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DWIDTH-1:0] d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_din;
    logic [DWIDTH-1:0] mem_dout;
    logic              stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_din, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_din, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data normally wins, fetch is forced through after
// MAX_WAIT refused cycles; read data returns one cycle after the grant.
module mem_arbiter #(
    parameter int AWIDTH   = 14,
    parameter int DWIDTH   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_arbiter_if.slave    bus
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RD_I = 3'b010,
        RD_D = 3'b100
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt, wait_nxt;
    logic              if_win, d_win;
    logic [AWIDTH-1:0] addr_sel;
    logic [DWIDTH-1:0] din_sel;
    logic [3:0]        we_sel;

    // Requests are ignored while reset is held, so every grant is gated by rst_n.
    always_comb begin
        if_win = 1'b0;
        d_win  = 1'b0;
        if (rst_n) begin
            if (bus.d_req && (!bus.if_req || (wait_cnt < MAX_W)))
                d_win = 1'b1;
            else if (bus.if_req)
                if_win = 1'b1;
        end
    end

    always_comb begin
        addr_sel = '0;
        din_sel  = '0;
        we_sel   = '0;
        if (d_win) begin
            addr_sel = bus.d_addr;
            din_sel  = bus.d_wdata;
            we_sel   = bus.d_we;
        end else if (if_win) begin
            addr_sel = bus.if_addr;
        end
    end

    always_comb begin
        wait_nxt = 4'd0;
        if (bus.if_req && !if_win)
            wait_nxt = (wait_cnt == MAX_W) ? wait_cnt : wait_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // A pending read is squashed while reset is held, even though the state
    // register only returns to IDLE at the next edge.
    always_comb begin
        state_nxt     = IDLE;
        bus.if_gnt    = if_win;
        bus.d_gnt     = d_win;
        bus.mem_en    = if_win | d_win;
        bus.mem_we    = we_sel;
        bus.mem_addr  = addr_sel;
        bus.mem_din   = din_sel;
        bus.stall     = rst_n & ((bus.if_req & !if_win) | (bus.d_req & !d_win));
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;

        if (if_win)
            state_nxt = RD_I;
        else if (d_win && (bus.d_we == 4'd0))
            state_nxt = RD_D;

        if (rst_n && (state == RD_I)) begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = bus.mem_dout;
        end
        if (rst_n && (state == RD_D)) begin
            bus.d_rvalid = 1'b1;
            bus.d_rdata  = bus.mem_dout;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the core's instruction-fetch and data (load/store) requesters. It sits between the RISC-V core and one unified, synchronous-read memory, granting at most one access per cycle. It returns read data with fixed one-cycle latency, raises a stall when a requester is refused, and bounds fetch starvation with a wait counter.

## Interface
- `AWIDTH`, 14, word-address width.
- `DWIDTH`, 32, data width.
- `MAX_WAIT`, 4, max consecutive refused fetch cycles before fetch is forced to win; legal range 1..15.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `if_req`  in  1  fetch request.
- `if_addr`  in  AWIDTH  fetch word address.
- `if_gnt`  out  1  fetch granted this cycle.
- `if_rvalid`  out  1  fetch data valid.
- `if_rdata`  out  DWIDTH  fetch data.
- `d_req`  in  1  data request.
- `d_we`  in  4  byte write mask; 0 means load.
- `d_addr`  in  AWIDTH  data word address.
- `d_wdata`  in  DWIDTH  store data, already lane-aligned.
- `d_gnt`  out  1  data granted this cycle.
- `d_rvalid`  out  1  load data valid.
- `d_rdata`  out  DWIDTH  load data.
- `mem_en`  out  1  memory access enable.
- `mem_we`  out  4  memory byte write mask.
- `mem_addr`  out  AWIDTH  memory address.
- `mem_din`  out  DWIDTH  memory write data.
- `mem_dout`  in  DWIDTH  memory read data, valid one cycle after `mem_en` with `mem_we`=0.
- `stall`  out  1  some request refused this cycle.

## Operation
- Requesters hold `req`, address, mask and data stable until their `gnt` is seen high. Dropping `req` before grant is legal and withdraws the request.
- Grant logic is combinational from requests and state.
  - Only `d_req`: data granted.
  - Only `if_req`: fetch granted.
  - Both, with `wait_cnt` < `MAX_WAIT`: data granted.
  - Both, with `wait_cnt` == `MAX_WAIT`: fetch granted.
  - `if_gnt` and `d_gnt` are never both 1.
- Memory port follows the winner:
  - `mem_en` = `if_gnt` | `d_gnt`.
  - `mem_addr` and `mem_din` come from the winner.
  - `mem_we` = `d_we` when data wins, else 0.
  - `mem_din` = 0 when fetch wins.
  - When idle, all `mem_*` outputs are 0.
- `wait_cnt`, 4 bits, saturating at `MAX_WAIT`:
  - Increments when `if_req` & !`if_gnt`.
  - Clears when `if_gnt` or !`if_req`.
- Read-tracking FSM, one-hot register with states IDLE, RD_I and RD_D:
  - Next state RD_I if `if_gnt`.
  - Next state RD_D if `d_gnt` & `d_we`==0.
  - Next state IDLE otherwise, including any store.
  - A grant is allowed in every state, so back-to-back reads pipeline.
- `if_rvalid` = (state==RD_I). `if_rdata` = `mem_dout` when `if_rvalid`, else 0.
- `d_rvalid` = (state==RD_D). `d_rdata` = `mem_dout` when `d_rvalid`, else 0.
- `stall` = (`if_req` & !`if_gnt`) | (`d_req` & !`d_gnt`).
- While `rst_n`=0, the block drives:
  - `if_gnt`, `d_gnt`, `mem_en` and `stall` to 0.
  - `mem_we`, `mem_addr` and `mem_din` to 0.
  - State to IDLE and `wait_cnt` to 0.
  - Requests are ignored.

## Timing
- Reset values for every output are 0.
- Grant latency is 0 cycles: a request is granted the same cycle it is presented if it wins.
- Read latency: grant in cycle N, `rvalid` and `rdata` in cycle N+1 only. There is no backpressure on read data.
- Stores complete in the grant cycle and produce no `rvalid`.
- Throughput is one access per cycle. Alternating fetch and load reads give `rvalid` on alternating requesters each cycle.
- Worst-case fetch wait under continuous data traffic is `MAX_WAIT` cycles. Grant comes on cycle `MAX_WAIT`+1 after first presentation.
- Reset asserted in the cycle after a read grant: the pending `rvalid` is dropped, and outputs are 0 in the following cycle.
- A request withdrawn while `wait_cnt`>0 clears `wait_cnt` the next cycle.

## Test plan
- Fetch read: `if_req`=1, `if_addr`=0x010, memory word 0x00000013.
  - Required: `if_gnt`=1 and `mem_en`=1 with `mem_addr`=0x010 in cycle N.
  - Required: `if_rvalid`=1 and `if_rdata`=0x00000013 in N+1; `stall`=0 throughout.
- Contention: `if_req` and `d_req` (load from 0x200) both asserted in cycle N.
  - Required: `d_gnt`=1 and `stall`=1 in N.
  - Required: `if_gnt`=1 and `d_rvalid`=1 in N+1.
  - Required: `if_rvalid`=1 in N+2.
- Starvation with `MAX_WAIT`=4: `if_req` held, `d_req` held for 8 cycles of loads.
  - Required: `d_gnt` in cycles 0-3, `if_gnt` in cycle 4, `d_gnt` in cycles 5-7.
  - Required: `wait_cnt` sequence 0,1,2,3,4,0.
- Store: `d_req`=1, `d_we`=4'b0100, `d_addr`=0x005, `d_wdata`=0x00AB0000.
  - Required: `mem_we`=4'b0100 and `mem_din`=0x00AB0000 in the grant cycle.
  - Required: `d_rvalid`=0 next cycle.
- Reset mid-read: load granted in cycle N, `rst_n`=0 in N+1.
  - Required: `d_rvalid`=0 and all outputs 0 during reset.
  - Required: a fetch after release behaves as in the first scenario.
- Withdrawal: `if_req` refused for 2 cycles, dropped for 1 cycle, then reasserted against continuous data traffic.
  - Required: `wait_cnt` restarts from 0, and fetch wins 4 cycles later.
